// File: rtl/fft_sample_writer.sv
// fft_sample_writer: captures one frame of 2**ADDR_WIDTH samples from a
// valid/ready stream into an internal RAM with a 1-cycle registered read port.
// Optional build macro BIT_REVERSE_EN stores samples at the bit-reversed write
// pointer (decimation-in-time order); otherwise samples land in natural order.
module fft_sample_writer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   waddr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef BIT_REVERSE_EN
    // Reverse bit order of the write pointer over ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] bit_rev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    assign waddr = bit_rev(wr_ptr_q);
`else
    assign waddr = wr_ptr_q;
`endif

    // Next-state, pointer and overflow logic; status flags follow next state.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CAPTURE;
                    wr_ptr_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = ADDR_WIDTH'(wr_ptr_q + 1'b1);
                    if (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d    = ST_CAPTURE;
                    wr_ptr_d   = '0;
                    overflow_d = 1'b0;
                end else if (in_valid) begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Sample RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[waddr] <= in_data;
        end
    end

    // Registered read port; same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign in_ready = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign count    = wr_ptr_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fft_sample_writer.sv
// Testbench for fft_sample_writer: directed frames plus random traffic,
// checked against a frame-level reference model with a shadow RAM.
module tb_fft_sample_writer;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] count;
    logic          busy;
    logic          done;
    logic          overflow;

    fft_sample_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: shadow RAM plus frame progress.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_known [DEPTH];
    bit            m_cap;
    bit            m_full;
    bit            m_ovf;
    int            m_cnt;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Storage slot of the n-th sample of a frame.
    function automatic int waddr_of(input int p);
        int r;
        r = p % DEPTH;
`ifdef BIT_REVERSE_EN
        begin
            int q;
            q = r;
            r = 0;
            for (int b = 0; b < AW; b++) begin
                if (((q >> b) & 1) == 1) r += 1 << (AW - 1 - b);
            end
        end
`endif
        return r;
    endfunction

    // Drive one clock cycle, advance the model, check all outputs.
    task automatic cycle(input bit rs, input bit st, input bit iv, input logic [DW-1:0] d, input int ra);
        logic [DW-1:0] exp_rd;
        bit            known;
        int            wa;
        reset    = rs;
        start    = st;
        in_valid = iv;
        in_data  = d;
        rd_addr  = AW'(ra);
        exp_rd   = ref_mem[ra];
        known    = ref_known[ra];
        @(posedge clk);
        #1;
        if (rs) begin
            m_cap = 0; m_full = 0; m_cnt = 0; m_ovf = 0;
            exp_rd = '0; known = 1;
        end else if (m_cap) begin
            if (iv) begin
                wa = waddr_of(m_cnt);
                ref_mem[wa]   = d;
                ref_known[wa] = 1;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_cnt = 0; m_cap = 0; m_full = 1;
                end
            end
        end else if (m_full) begin
            if (st) begin
                m_full = 0; m_cap = 1; m_cnt = 0; m_ovf = 0;
            end else if (iv) begin
                m_ovf = 1;
            end
        end else if (st) begin
            m_cap = 1; m_cnt = 0; m_ovf = 0;
        end
        check("busy",     DW'(busy),     DW'(m_cap));
        check("in_ready", DW'(in_ready), DW'(m_cap));
        check("done",     DW'(done),     DW'(m_full));
        check("count",    DW'(count),    DW'(m_cnt));
        check("overflow", DW'(overflow), DW'(m_ovf));
        if (known) check("rd_data", rd_data, exp_rd);
    endtask

    task automatic readback_all();
        for (int k = 0; k < DEPTH; k++) cycle(0, 0, 0, '0, k);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_cap = 0; m_full = 0; m_ovf = 0; m_cnt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            ref_mem[k]   = '0;
            ref_known[k] = 0;
        end
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;

        // Reset state
        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 0);

        // Test 1: full frame, valid every cycle, then read back
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, DW'(32'h100 + i), $urandom_range(DEPTH - 1));
        cycle(0, 0, 0, '0, 0);
        readback_all();

        // Test 3: overflow after done, then restart with valid in same cycle
        cycle(0, 0, 1, 32'hDEAD_0001, 1);
        cycle(0, 0, 1, 32'hDEAD_0002, 2);
        cycle(0, 0, 0, '0, 3);
        cycle(0, 1, 1, 32'hDEAD_0003, 0);

        // Test 2: same stream with valid toggling; start ignored while capturing
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 1, DW'(32'h100 + i), $urandom_range(DEPTH - 1));
            if (i != DEPTH - 1) cycle(0, (i % 7) == 0, 0, 32'hBAD0_0000, $urandom_range(DEPTH - 1));
        end
        readback_all();

        // Test 6: read the slot being written, then the slot just written
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) cycle(0, 0, 1, $urandom, waddr_of(m_cnt));
            else            cycle(0, 0, 1, $urandom, waddr_of(m_cnt + DEPTH - 1));
        end
        readback_all();

        // Test 4: reset after 20 transfers, then a fresh full frame
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, DW'(32'h200 + i), waddr_of(i));
        cycle(1, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, waddr_of(5));
        cycle(0, 0, 1, 32'hBEEF, 5);
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, ($urandom % 3) != 0 || i == 0, $urandom, $urandom_range(DEPTH - 1));
        for (int i = 0; i < 2 * DEPTH && !m_full; i++) cycle(0, 0, 1, $urandom, $urandom_range(DEPTH - 1));
        readback_all();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 300) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
                  $urandom, $urandom_range(DEPTH - 1));
        end
        readback_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
